// File: rtl/score_seq_pkg.sv
// -----------------------------------------------------------------------------
// score_seq_pkg
// Shared definitions for the score sequencer: score word layout, special
// field values, common widths and the sequencer state encoding.
// Helper functions split a 10-bit score word {dur[9:6], note[5:0]}.
// -----------------------------------------------------------------------------
package score_seq_pkg;

  // Score word field positions
  localparam int DUR_MSB  = 9;
  localparam int DUR_LSB  = 6;
  localparam int NOTE_MSB = 5;

  // Common widths
  localparam int WORD_W = 10;
  localparam int DUR_W  = 4;
  localparam int NOTE_W = 6;
  localparam int LOW_W  = 10;
  localparam int CROT_W = 7;
  localparam int POS_W  = 16;

  // Special field values
  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
  localparam logic [DUR_W-1:0]  DUR_END   = 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    PLAY   = 2'd3
  } seq_state_e;

  // Duration field of a score word
  function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
    return w[DUR_MSB:DUR_LSB];
  endfunction

  // Note field of a score word
  function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
    return w[NOTE_MSB:0];
  endfunction

endpackage

// File: rtl/score_sequencer_beat_timer.sv
// -----------------------------------------------------------------------------
// beat_timer
// Beat timebase: a clock divider (0..LOW_DIV-1) advancing a 10-bit
// sub-crotchet phase, which in turn advances a 7-bit crotchet index.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   run_i               advance the divider this cycle (otherwise hold)
//   clear_crotchet_i    force crotchet to 0 (wins over load and increment)
//   load_crotchet_i     load crotchet from load_value_i (wins over increment)
//   load_value_i        crotchet load value
//   low_count_o         sub-crotchet phase (registered)
//   crotchet_o          beat index (registered)
//   beat_o              high in the cycle whose edge increments crotchet
// -----------------------------------------------------------------------------
module beat_timer
  import score_seq_pkg::*;
#(
  parameter int LOW_DIV = 17578
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              clear_crotchet_i,
  input  logic              load_crotchet_i,
  input  logic [CROT_W-1:0] load_value_i,
  output logic [LOW_W-1:0]  low_count_o,
  output logic [CROT_W-1:0] crotchet_o,
  output logic              beat_o
);

  localparam int DIV_W = (LOW_DIV > 1) ? $clog2(LOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LOW_DIV - 1);
  localparam logic [LOW_W-1:0] LOW_LAST = 10'd1023;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [LOW_W-1:0]  low_q, low_d;
  logic [CROT_W-1:0] crot_q, crot_d;
  logic              div_wrap_s;
  logic              low_wrap_s;

  // Next-state logic for divider, phase and crotchet
  always_comb begin
    div_d      = div_q;
    low_d      = low_q;
    crot_d     = crot_q;
    div_wrap_s = run_i && (div_q == DIV_LAST);
    low_wrap_s = div_wrap_s && (low_q == LOW_LAST);

    if (run_i) begin
      if (div_wrap_s) begin
        div_d = {DIV_W{1'b0}};
        low_d = low_q + 10'd1;
      end else begin
        div_d = div_q + DIV_W'(1'b1);
      end
    end else begin
      div_d = div_q;
    end

    // A forced clear from the end marker overrides a coincident beat
    if (clear_crotchet_i) begin
      crot_d = 7'd0;
    end else if (load_crotchet_i) begin
      crot_d = load_value_i;
    end else if (low_wrap_s) begin
      crot_d = crot_q + 7'd1;
    end else begin
      crot_d = crot_q;
    end
  end

  // Timebase registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= {DIV_W{1'b0}};
      low_q  <= 10'd0;
      crot_q <= 7'd0;
    end else begin
      div_q  <= div_d;
      low_q  <= low_d;
      crot_q <= crot_d;
    end
  end

  assign low_count_o = low_q;
  assign crotchet_o  = crot_q;
  assign beat_o      = low_wrap_s;

endmodule

// File: rtl/score_sequencer.sv
// -----------------------------------------------------------------------------
// score_sequencer
// Steps a song score held in a synchronous ROM, owns the beat timebase and
// hands each new note to the tone generator with a one-cycle strobe.
// fast_start selects a starting section; the score is fast-forwarded to that
// section silently, with the timebase parked at zero until the first note.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   pause       (SCORE_SEQ_PAUSE_EN only) freeze timebase and mute note
//   fast_start  start section, sampled in IDLE
//   rom_addr    score ROM address (registered)
//   rom_data    score word {dur[9:6], note[5:0]}, valid one cycle after addr
//   note        current note index, 0 = rest (registered)
//   note_stb    one-cycle pulse when note is updated (registered)
//   low_count   sub-crotchet phase
//   crotchet    beat index
//   playing     high from the first note strobe until reset
//
// Build option: define SCORE_SEQ_PAUSE_EN to add the pause input.
// -----------------------------------------------------------------------------
module score_sequencer
  import score_seq_pkg::*;
#(
  parameter int LOW_DIV           = 17578,
  parameter int SECTION_CROTCHETS = 32,
  parameter int ROM_AW            = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SCORE_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [1:0]        fast_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note,
  output logic              note_stb,
  output logic [LOW_W-1:0]  low_count,
  output logic [CROT_W-1:0] crotchet,
  output logic              playing
);

  localparam logic [POS_W-1:0] SEC_LEN = POS_W'(SECTION_CROTCHETS);

  seq_state_e        state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              stb_q, stb_d;
  logic              playing_q, playing_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]  s_q, s_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic              skip_q, skip_d;

  logic [DUR_W-1:0]  dur_s;
  logic [NOTE_W-1:0] word_note_s;
  logic [POS_W-1:0]  pos_sum_s;
  logic [POS_W-1:0]  start_s;
  logic              idle_skip_s;
  logic              run_s;
  logic              beat_s;
  logic              clear_crot_s;
  logic              load_crot_s;
  logic              pause_s;
  logic              release_s;

  assign dur_s       = word_dur(rom_data);
  assign word_note_s = word_note(rom_data);
  assign pos_sum_s   = pos_q + POS_W'(dur_s);
  assign start_s     = POS_W'(fast_start) * SEC_LEN;

  // The IDLE cycle that arms a skip must not let the divider take a step,
  // so the timebase looks ahead at the skip flag being set this cycle.
  assign idle_skip_s = (state_q == IDLE) && (start_s != {POS_W{1'b0}});
  assign run_s       = !skip_q && !idle_skip_s && !pause_s;

  beat_timer #(
    .LOW_DIV (LOW_DIV)
  ) u_beat_timer (
    .clk              (clk),
    .rst_n            (rst_n),
    .run_i            (run_s),
    .clear_crotchet_i (clear_crot_s),
    .load_crotchet_i  (load_crot_s),
    .load_value_i     (s_q[CROT_W-1:0]),
    .low_count_o      (low_count),
    .crotchet_o       (crotchet),
    .beat_o           (beat_s)
  );

  // Sequencer next-state and datapath decisions
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    note_d       = note_q;
    stb_d        = release_s;
    playing_d    = playing_q;
    pos_d        = pos_q;
    s_d          = s_q;
    rem_d        = rem_q;
    skip_d       = skip_q;
    clear_crot_s = 1'b0;
    load_crot_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pause_s) begin
          state_d = IDLE;
        end else begin
          s_d     = start_s;
          pos_d   = {POS_W{1'b0}};
          skip_d  = idle_skip_s;
          state_d = FETCH;
        end
      end

      FETCH: begin
        state_d = DECODE;
      end

      DECODE: begin
        if (dur_s == DUR_END) begin
          // End of song: restart from the top; the divider keeps its phase
          addr_d       = {ROM_AW{1'b0}};
          pos_d        = {POS_W{1'b0}};
          skip_d       = 1'b0;
          clear_crot_s = 1'b1;
          state_d      = FETCH;
        end else if (skip_q && (pos_sum_s <= s_q)) begin
          // Note lies wholly before the start section: pass over it silently
          pos_d   = pos_sum_s;
          addr_d  = addr_q + ROM_AW'(1'b1);
          state_d = FETCH;
        end else begin
          note_d    = word_note_s;
          stb_d     = 1'b1;
          playing_d = 1'b1;
          if (skip_q) begin
            // Note straddles the start point: play only its remaining part
            rem_d       = DUR_W'(pos_sum_s - s_q);
            load_crot_s = 1'b1;
            skip_d      = 1'b0;
          end else begin
            rem_d = dur_s;
          end
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (beat_s) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            addr_d  = addr_q + ROM_AW'(1'b1);
            state_d = FETCH;
          end else begin
            state_d = PLAY;
          end
        end else begin
          state_d = PLAY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= {ROM_AW{1'b0}};
      note_q    <= NOTE_REST;
      stb_q     <= 1'b0;
      playing_q <= 1'b0;
      pos_q     <= {POS_W{1'b0}};
      s_q       <= {POS_W{1'b0}};
      rem_q     <= 4'd0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      stb_q     <= stb_d;
      playing_q <= playing_d;
      pos_q     <= pos_d;
      s_q       <= s_d;
      rem_q     <= rem_d;
      skip_q    <= skip_d;
    end
  end

`ifdef SCORE_SEQ_PAUSE_EN
  logic              pause_q;
  logic [NOTE_W-1:0] note_out_q;

  assign pause_s   = pause;
  // Leaving pause re-announces the held note to the tone generator
  assign release_s = pause_q && !pause;

  // Pause edge detector and muted note output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pause_q    <= 1'b0;
      note_out_q <= NOTE_REST;
    end else begin
      pause_q    <= pause;
      note_out_q <= pause ? NOTE_REST : note_d;
    end
  end

  assign note = note_out_q;
`else
  assign pause_s   = 1'b0;
  assign release_s = 1'b0;
  assign note      = note_q;
`endif

  assign rom_addr = addr_q;
  assign note_stb = stb_q;
  assign playing  = playing_q;

endmodule

// File: tb/tb_score_sequencer.sv
module tb_score_sequencer;
  logic       clk;
  logic       rst_n;
  logic [1:0] fast_start;
  logic [7:0] rom_addr;
  logic [9:0] rom_data;
  logic [5:0] note;
  logic       note_stb;
  logic [9:0] low_count;
  logic [6:0] crotchet;
  logic       playing;
`ifdef SCORE_SEQ_PAUSE_EN
  logic       pause;
`endif

  logic [9:0] rom_mem [256];
  int checks;
  int errors;

  score_sequencer #(
    .LOW_DIV           (4),
    .SECTION_CROTCHETS (41),
    .ROM_AW            (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SCORE_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .fast_start (fast_start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .note_stb   (note_stb),
    .low_count  (low_count),
    .crotchet   (crotchet),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous score ROM
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [9:0] w(input int d, input int n);
    logic [3:0] dd;
    logic [5:0] nn;
    dd = 4'(d);
    nn = 6'(n);
    return {dd, nn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = 10'd0;
  endtask

  // Song of 3 crotchets: (2,5) (1,7) end
  task automatic load_basic();
    clear_rom();
    rom_mem[0] = w(2, 5);
    rom_mem[1] = w(1, 7);
    rom_mem[2] = w(0, 0);
  endtask

  // Long song: eight 15-beat notes, (3,9), rest (4,0), (2,11), end
  task automatic load_long();
    clear_rom();
    for (int i = 0; i < 8; i++) rom_mem[i] = w(15, i + 1);
    rom_mem[8]  = w(3, 9);
    rom_mem[9]  = w(4, 0);
    rom_mem[10] = w(2, 11);
    rom_mem[11] = w(0, 0);
  endtask

  task automatic restart(input logic [1:0] fs, input bit long_song);
    @(negedge clk);
    rst_n = 1'b0;
    fast_start = fs;
    if (long_song) load_long(); else load_basic();
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    fast_start = 2'd0;
`ifdef SCORE_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    load_basic();
    step(2);

    // ---- reset state ----
    check("rst_addr", rom_addr, 0);
    check("rst_note", note, 0);
    check("rst_stb", note_stb, 0);
    check("rst_low", low_count, 0);
    check("rst_crot", crotchet, 0);
    check("rst_playing", playing, 0);

    // ---- basic playback, fast_start=0 ----
    rst_n = 1'b1;
    step(2);
    check("basic_nostb_early", note_stb, 0);
    step(1);
    check("basic_stb1", note_stb, 1);
    check("basic_note5", note, 5);
    check("basic_playing", playing, 1);
    step(4092);
    check("basic_low1023", low_count, 1023);
    check("basic_crot0", crotchet, 0);
    step(1);
    check("basic_crot1", crotchet, 1);
    check("basic_low0", low_count, 0);
    step(4096);
    check("basic_crot2", crotchet, 2);
    check("basic_addr1", rom_addr, 1);
    check("basic_nostb_b", note_stb, 0);
    step(1);
    check("basic_nostb_c", note_stb, 0);
    step(1);
    check("basic_stb7", note_stb, 1);
    check("basic_note7", note, 7);
    step(4094);
    check("basic_crot3", crotchet, 3);
    check("basic_addr2", rom_addr, 2);
    step(2);
    check("basic_end_crot", crotchet, 0);
    check("basic_end_addr", rom_addr, 0);
    step(2);
    check("basic_restb", note_stb, 1);
    check("basic_renote5", note, 5);

    // ---- section skip: fast_start=1 -> start at crotchet 41 ----
    restart(2'd1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check("skip_nostb", note_stb, 0);
      check("skip_low0", low_count, 0);
    end
    step(1);
    check("skip_stb", note_stb, 1);
    check("skip_note3", note, 3);
    check("skip_crot41", crotchet, 41);
    check("skip_low_at_stb", low_count, 0);
    check("skip_addr2", rom_addr, 2);
    step(16384);
    check("skip_crot45", crotchet, 45);
    check("skip_addr3", rom_addr, 3);
    check("skip_nostb_d", note_stb, 0);
    step(2);
    check("skip_stb4", note_stb, 1);
    check("skip_note4", note, 4);

    // ---- start beyond song: 3-beat song, start at crotchet 41 ----
    restart(2'd1, 1'b0);
    step(8);
    check("beyond_nostb", note_stb, 0);
    step(1);
    check("beyond_stb", note_stb, 1);
    check("beyond_note5", note, 5);
    check("beyond_crot0", crotchet, 0);
    check("beyond_addr0", rom_addr, 0);
    check("beyond_low0", low_count, 0);

    // ---- rest and crotchet wrap: start at crotchet 123 ----
    restart(2'd3, 1'b1);
    step(20);
    check("rest_nostb", note_stb, 0);
    step(1);
    check("rest_stb", note_stb, 1);
    check("rest_note0", note, 0);
    check("rest_crot123", crotchet, 123);
    check("rest_addr9", rom_addr, 9);
    step(12288);
    check("rest_crot126", crotchet, 126);
    check("rest_hold_note", note, 0);
    check("rest_hold_addr", rom_addr, 9);
    step(4096);
    check("rest_crot127", crotchet, 127);
    check("rest_addr10", rom_addr, 10);
    check("rest_nostb_e", note_stb, 0);
    step(2);
    check("wrap_stb11", note_stb, 1);
    check("wrap_note11", note, 11);
    step(4094);
    check("wrap_crot0", crotchet, 0);
    check("wrap_addr10", rom_addr, 10);
    step(4096);
    check("wrap_crot1", crotchet, 1);
    check("wrap_addr11", rom_addr, 11);
    step(2);
    check("wrap_end_crot", crotchet, 0);
    check("wrap_end_addr", rom_addr, 0);
    step(2);
    check("wrap_restb", note_stb, 1);
    check("wrap_renote1", note, 1);

    // ---- reset mid-note at crotchet 5 ----
    restart(2'd0, 1'b1);
    step(3);
    check("mid_stb", note_stb, 1);
    check("mid_note1", note, 1);
    step(20477);
    check("mid_crot5", crotchet, 5);
    check("mid_playing", playing, 1);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_addr", rom_addr, 0);
    check("mid_rst_note", note, 0);
    check("mid_rst_stb", note_stb, 0);
    check("mid_rst_low", low_count, 0);
    check("mid_rst_crot", crotchet, 0);
    check("mid_rst_playing", playing, 0);
    rst_n = 1'b1;
    step(3);
    check("mid_replay_stb", note_stb, 1);
    check("mid_replay_note", note, 1);
    check("mid_replay_addr", rom_addr, 0);
    check("mid_replay_crot", crotchet, 0);

`ifdef SCORE_SEQ_PAUSE_EN
    // ---- pause for 100 cycles at low_count 300 ----
    step(1197);
    check("pause_low300_pre", low_count, 300);
    pause = 1'b1;
    step(1);
    check("pause_note0", note, 0);
    check("pause_low_a", low_count, 300);
    step(99);
    check("pause_low_b", low_count, 300);
    check("pause_note0_b", note, 0);
    check("pause_nostb", note_stb, 0);
    check("pause_crot", crotchet, 0);
    pause = 1'b0;
    step(1);
    check("release_stb", note_stb, 1);
    check("release_note", note, 1);
    check("release_low", low_count, 300);
    step(4);
    check("release_low301", low_count, 301);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Steps a song score stored in a synchronous score ROM.
- Owns the beat timebase: emits `low_count` (sub-crotchet phase) and `crotchet` (beat index), which the tone generator and the VGA display both consume.
- Issues each new note to the PWM tone generator as a one-cycle strobe.
- `fast_start` selects a starting section; the block fast-forwards through the score to that section without playing it.

Parameters:
- LOW_DIV, 17578, clk cycles per `low_count` step (crotchet = 1024*LOW_DIV cycles; 0.5 s at 36 MHz); must be >= 4
- SECTION_CROTCHETS, 32, crotchets per `fast_start` section
- ROM_AW, 8, score ROM address width

Ports:
- clk  in  1  system clock (36 MHz PLL output)
- rst_n  in  1  reset, synchronous, active-low
- fast_start  in  2  start section; sampled in IDLE
- rom_addr  out  ROM_AW  score ROM address, registered
- rom_data  in  10  score word {dur[9:6], note[5:0]}; valid the cycle after rom_addr changes
- note  out  6  current note index, 0 = rest
- note_stb  out  1  one-cycle pulse when note is updated
- low_count  out  10  sub-crotchet phase
- crotchet  out  7  beat index
- playing  out  1  high from the first note_stb until reset

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; rom_addr, note, note_stb, low_count, crotchet, playing, divider, pos and remaining all 0; skip flag cleared.
- IDLE (first cycle after reset): latch S = fast_start*SECTION_CROTCHETS; pos=0; skip = (S!=0); go to FETCH.
- FETCH: rom_addr holds addr; go to DECODE next cycle.
- DECODE: capture rom_data.
  - If dur==0 (end marker): addr=0, pos=0, skip=0, crotchet forced to 0; go to FETCH. The divider is not reset.
  - Else if skip and pos+dur <= S: pos += dur; addr++; go to FETCH. No strobe is issued.
  - Else: note=rom_data.note; note_stb=1 for this cycle; playing=1.
    - If skip: remaining = pos+dur-S; crotchet = S[6:0]; skip cleared.
    - Otherwise: remaining = dur.
    - Go to PLAY.
- Timebase:
  - While skip is set, divider and low_count hold 0.
  - Once skip is clear, the timebase runs freely in every state, including FETCH/DECODE, so beat timing never slips.
  - The divider counts 0..LOW_DIV-1; at wrap, low_count increments (10-bit).
  - When low_count wraps 1023->0, crotchet increments (7-bit wrap 127->0).
- PLAY: on each crotchet increment, remaining--. When remaining reaches 0: addr++ and go to FETCH. The next note_stb lands 2 cycles after the beat edge.
- Address wrap: addr wraps from 2^ROM_AW-1 to 0 modulo width.
- End marker during skip: S is beyond the song, so playback starts from crotchet 0, address 0.
- Rest (note 0): strobed and timed like any other note.
- End-marker force wins over a simultaneous crotchet increment.
- Reset mid-operation: all state returns to its reset values on the next edge; fast_start is re-sampled.

Optional Feature:
- Macro: SCORE_SEQ_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause is high, the divider, low_count, crotchet and remaining freeze, and the `note` output reads 0.
  - The FSM completes any in-flight FETCH/DECODE, then holds. A strobe from that DECODE is still issued, and the note is latched internally.
  - On release, counting resumes from the frozen values, the latched note reappears, and note_stb pulses once.
- Undefined: the port is absent and the behaviour is as above.

Decomposition:
- Package score_seq_pkg:
  - score word field positions: DUR_MSB=9, DUR_LSB=6, NOTE_MSB=5
  - NOTE_REST=0, DUR_END=0
  - state enum {IDLE, FETCH, DECODE, PLAY}
- Sub-module beat_timer:
  - contents: divider, low_count and crotchet
  - inputs: run, clear_crotchet, load_crotchet with value
  - output: a beat pulse

Test Plan:
- Basic playback:
  - Stimulus: LOW_DIV=4, ROM {(2,5),(1,7),(0,0)}, fast_start=0.
  - Response: note_stb with note=5 in the 3rd cycle after rst_n rises. crotchet=1 after 4096 cycles. note=7 strobed 2 cycles after crotchet becomes 2. At crotchet 3 the end marker forces crotchet=0 and note=5 is re-strobed.
- Section skip:
  - Stimulus: SECTION_CROTCHETS=2, ROM {(1,3),(3,9),(0,0)}, fast_start=1.
  - Response: no strobe for note 3. First strobe is note=9 with crotchet=2 and remaining=2, so the next fetch happens after 2 beats. low_count is 0 until that strobe.
- Start beyond song:
  - Stimulus: fast_start=3, SECTION_CROTCHETS=32, song length 10 crotchets.
  - Response: first strobe is entry 0 with crotchet=0.
- Rest and wrap:
  - Stimulus: ROM entry (4,0); run the crotchet counter past 127.
  - Response: note_stb with note=0, held for 4 beats. crotchet wraps 127->0 without disturbing the sequence.
- Reset mid-note:
  - Stimulus: drop rst_n for 1 cycle during PLAY, at crotchet=5.
  - Response: next cycle all outputs are 0. Replay from address 0.
- Pause (SCORE_SEQ_PAUSE_EN defined):
  - Stimulus: pause for 100 cycles at low_count=300.
  - Response: low_count holds 300 and note reads 0. On release, note is restored with one note_stb and counting continues from 300.
